// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a registered valid/ready read port,
// flush, alignment/range fault detection and a byte-wide programming port.
module imem_fetch_port #(
    parameter int          ADDR_W      = 64,
    parameter int          DEPTH_BYTES = 256,
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    parameter int          CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_inst,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_fault,
    input  logic              flush,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [CNT_W-1:0]  fetch_count
);
    localparam int                IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH_BYTES - 1);

    logic [7:0]       mem [DEPTH_BYTES];
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic             req_fault;
    logic             accept;
    logic             consume;

    // Full-width compare so addresses past the end never alias back to low bytes.
    function automatic logic is_fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    always_comb begin
        rd_idx    = req_addr[IDX_W-1:0];
        rd_word   = {mem[rd_idx + IDX_W'(3)], mem[rd_idx + IDX_W'(2)],
                     mem[rd_idx + IDX_W'(1)], mem[rd_idx]};
        req_fault = is_fault(req_addr);
        req_ready = (!resp_valid || resp_ready) && !flush;
        accept    = req_valid && req_ready;
        consume   = resp_valid && resp_ready;
    end

    // Read happens from the pre-edge contents, so a same-cycle write is seen only by later fetches.
    always_ff @(posedge clk) begin
        if (prog_en && (prog_addr <= LAST_BYTE)) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    // Response register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid  <= 1'b0;
            resp_inst   <= NOP_INST;
            resp_addr   <= '0;
            resp_fault  <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (consume) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (flush) begin
                resp_valid <= 1'b0;
                resp_fault <= 1'b0;
            end else if (accept) begin
                resp_valid <= 1'b1;
                resp_addr  <= req_addr;
                resp_fault <= req_fault;
                resp_inst  <= req_fault ? NOP_INST : rd_word;
            end else if (consume) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed and randomized bench for imem_fetch_port against a byte-array reference model.
module tb_imem_fetch_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [63:0] resp_addr;
    logic        resp_fault;
    logic        flush;
    logic        prog_en;
    logic [63:0] prog_addr;
    logic [7:0]  prog_data;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [7:0]  mem_m [256];
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = 32'h00000013;
    logic [63:0] m_addr  = '0;
    logic        m_fault = 1'b0;
    logic [31:0] m_count = '0;

    imem_fetch_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst),
        .resp_addr(resp_addr), .resp_fault(resp_fault), .flush(flush),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("resp_valid",  {63'd0, resp_valid}, {63'd0, m_valid});
        chk("resp_inst",   {32'd0, resp_inst},  {32'd0, m_inst});
        chk("resp_addr",   resp_addr,           m_addr);
        chk("resp_fault",  {63'd0, resp_fault}, {63'd0, m_fault});
        chk("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_inst  = 32'h00000013;
        m_addr  = '0;
        m_fault = 1'b0;
        m_count = '0;
    endtask

    // What the fetch port should hold after one rising edge with the given inputs.
    task automatic model_edge(input logic rv, input logic [63:0] ra, input logic rr,
                              input logic fl, input logic pe, input logic [63:0] pa,
                              input logic [7:0] pd);
        logic consumed;
        logic taken;
        consumed = m_valid && rr;
        taken    = rv && !fl && (!m_valid || rr);
        if (consumed) m_count = m_count + 1;
        if (fl) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (taken) begin
            m_valid = 1'b1;
            m_addr  = ra;
            m_fault = (ra % 4 != 0) || (ra > 64'd252);
            if (m_fault) m_inst = 32'h00000013;
            else m_inst = {mem_m[ra], mem_m[ra + 1], mem_m[ra + 2], mem_m[ra + 3]} == 0 ? 32'd0 :
                          (32'(mem_m[ra]) | (32'(mem_m[ra + 1]) << 8) |
                           (32'(mem_m[ra + 2]) << 16) | (32'(mem_m[ra + 3]) << 24));
        end else if (consumed) begin
            m_valid = 1'b0;
        end
        if (pe && pa < 64'd256) mem_m[pa] = pd;
    endtask

    task automatic cyc(input logic rv, input logic [63:0] ra, input logic rr,
                       input logic fl, input logic pe, input logic [63:0] pa,
                       input logic [7:0] pd);
        req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
        prog_en = pe; prog_addr = pa; prog_data = pd;
        #1;
        chk("req_ready", {63'd0, req_ready}, {63'd0, (!m_valid || rr) && !fl});
        @(posedge clk);
        if (reset) model_edge(rv, ra, rr, fl, pe, pa, pd);
        #1;
        check_outputs();
    endtask

    task automatic prog_word(input logic [63:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, a + 64'(b), w[8*b +: 8]);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            6:       return 64'($urandom_range(0, 255) | 1);
            7:       return 64'($urandom_range(256, 1023));
            8:       return {$urandom, $urandom};
            9:       return 64'd252;
            default: return 64'($urandom_range(0, 63) * 4);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        flush = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        reset = 1'b1;

        for (int i = 0; i < 256; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'(i), 8'($urandom));
        prog_word(64'd0, 32'h00300293);
        prog_word(64'd4, 32'h00503223);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd16, 8'h13);

        // Back-to-back fetches
        cyc(1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("inst0", {32'd0, resp_inst}, 64'h00300293);
        cyc(1'b1, 64'd4, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("inst4", {32'd0, resp_inst}, 64'h00503223);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("count2", {32'd0, fetch_count}, 64'd2);

        // Back-pressure with a program write to the held word
        cyc(1'b1, 64'd8, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'd12, 1'b0, 1'b0, 1'b1, 64'd8, 8'hEE);
        chk("stall_addr", resp_addr, 64'd8);
        cyc(1'b1, 64'd12, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("after_stall_addr", resp_addr, 64'd12);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);

        // Faults
        cyc(1'b1, 64'd6, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("mis_fault", {63'd0, resp_fault}, 64'd1);
        cyc(1'b1, 64'd256, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("range_inst", {32'd0, resp_inst}, 64'h13);
        cyc(1'b1, 64'd252, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);

        // Flush with and without consumption
        cyc(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
        cyc(1'b1, 64'd4, 1'b0, 1'b1, 1'b0, 64'd0, 8'h00);
        cyc(1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        cyc(1'b1, 64'd4, 1'b1, 1'b1, 1'b0, 64'd0, 8'h00);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);

        // Same-cycle program and fetch of byte 16
        cyc(1'b1, 64'd16, 1'b1, 1'b0, 1'b1, 64'd16, 8'hAB);
        chk("rbw_old", {56'd0, resp_inst[7:0]}, 64'h13);
        cyc(1'b1, 64'd16, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("rbw_new", {56'd0, resp_inst[7:0]}, 64'hAB);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);

        // Asynchronous reset while a response is held
        cyc(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cyc(1'b1, 64'd4, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        reset = 1'b1;
        cyc(1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00);
        chk("post_rst_inst", {32'd0, resp_inst}, 64'h00300293);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
                64'($urandom_range(0, 300)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
